simplez_loader: RTL and testbench
=================================

Name: simplez_loader

Overview:
- Serial program loader for the Simplez core: the writer that fills the program RAM the CPU reads.
- Takes bytes from the uart_rx unit (rcv pulse plus data) and assembles 12-bit words.
- Writes the words into the RAM write port while holding the CPU in reset, then answers through the uart_tx unit.
- Sits between the UART pair and the CPU/RAM at top level; the CPU's reset input is driven from cpu_rstn.

Parameters:
- BOOT_RUN, 1, after reset release the CPU: 1 runs the preloaded ROMFILE program, 0 stays halted until a good load.
- RAM_WORDS, 504, number of loadable RAM words (0x000–0x1F7); peripheral addresses are never written.
- TIMEOUT, 32'd1200000, maximum idle clocks between bytes inside a frame (only with the macro).

Ports:
- clk, in, 1, system clock.
- rstn, in, 1, reset, asynchronous, active-low.
- rx_rcv, in, 1, one-cycle pulse from uart_rx: byte valid.
- rx_data, in, 8, received byte, valid when rx_rcv=1.
- ack_ready, in, 1, uart_tx ready.
- ack_start, out, 1, one-cycle pulse to uart_tx.
- ack_data, out, 8, response byte, stable from ack_start until ack_ready returns high.
- mem_addr, out, 9, RAM write address.
- mem_din, out, 12, RAM write data.
- mem_we, out, 1, one-cycle RAM write strobe.
- cpu_rstn, out, 1, active-low reset to the CPU.
- busy, out, 1, frame in progress.
- error, out, 1, sticky: last frame failed.

Behaviour:
- Reset (async): state=IDLE, all outputs 0. This includes cpu_rstn=0, mem_addr=0 and ack_data=0x00. Partial load state is discarded.
- First clock after reset deasserts: cpu_rstn=BOOT_RUN.
- Frame format: 0x4C ('L'), LEN_H, LEN_L, then LEN words of 2 bytes each (HI, LO), then CSUM.
  - LEN is 9 bits: {LEN_H[0], LEN_L}.
  - Word = {HI[3:0], LO}.
  - CSUM = 8-bit wrap-around sum of all HI and LO bytes.
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CSUM, ACK.
- IDLE: non-0x4C bytes are ignored. On 0x4C the block sets cpu_rstn=0, busy=1, error=0, addr=0, sum=0 and goes to LEN_H.
- LEN_H: if rx_data[7:1]≠0, go to the error path. Otherwise latch the bit and go to LEN_L.
- LEN_L: if LEN=0 or LEN>RAM_WORDS, go to the error path. Otherwise go to DATA_H.
- DATA_H: if HI[7:4]≠0, go to the error path. Otherwise latch the byte, add it to sum, and go to DATA_L.
- DATA_L: latch LO, add it to sum, go to WRITE.
- WRITE: one cycle with mem_we=1, mem_addr=current addr, mem_din=word. Next cycle addr+1.
  - If addr+1=LEN, go to CSUM; else go to DATA_H.
  - Write latency: strobe occurs 1 clock after the rx_rcv carrying LO.
- CSUM: match gives ack_data=0x4B ('K'); mismatch gives ack_data=0x45 ('E').
- Error path: ack_data=0x45, error=1, go to ACK. Remaining frame bytes are ignored until the next 0x4C.
- ACK: wait for ack_ready=1, then pulse ack_start for one cycle and go to IDLE with busy=0.
  - On 'K': cpu_rstn=1 in the same cycle as ack_start.
  - On 'E': cpu_rstn stays 0.
- rx_rcv received while in WRITE or ACK is dropped (not buffered). Senders must not stream faster than one byte per UART frame; at UART rates this cannot occur.
- 9-bit addr never exceeds RAM_WORDS-1; no wrap-around is possible.
- New 0x4C received mid-frame is treated as data, not as a restart.

Optional Feature:
- SIMPLEZ_LOADER_TIMEOUT_EN defined: a counter clears on every rx_rcv while busy.
  - Reaching TIMEOUT in any state except IDLE/ACK takes the error path ('E' sent, error=1).
- Macro undefined: no counter and no timeout; a stalled frame waits forever. TIMEOUT is unused.

Test Plan:
- Load 2 words: L,00,02,05,A3,00,7F,CSUM=0x27 → writes 0x5A3@0 and 0x07F@1, 'K' sent, cpu_rstn 0→1, error=0.
- Same frame with CSUM=0x28 → both writes occur, 'E' sent, cpu_rstn stays 0, error=1.
- LEN=01,F9 (505) → no mem_we, 'E' sent immediately after LEN_L; byte HI=0x15 in another frame → 'E'.
- Reset pulse mid-DATA_L → all outputs 0 asynchronously; next cycle cpu_rstn=BOOT_RUN; no spurious mem_we.
- Bytes 0x00,0xFF in IDLE → ignored, busy=0; hold ack_ready=0 in ACK for 100 clocks → ack_start only after ack_ready rises.
- With SIMPLEZ_LOADER_TIMEOUT_EN, TIMEOUT=100: send L,00 then stop → 'E' after 100 clocks, error=1; without the macro → busy stays 1.

Source files
------------

// File: rtl/simplez_loader.sv
// Serial program loader: assembles 12-bit words from UART bytes, writes program RAM, holds the CPU in reset.
// Optional inter-byte timeout is compiled in with `define SIMPLEZ_LOADER_TIMEOUT_EN.
module simplez_loader #(
    parameter bit          BOOT_RUN  = 1'b1,
    parameter int          RAM_WORDS = 504,
    parameter logic [31:0] TIMEOUT   = 32'd1200000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_rcv,
    input  logic [7:0] rx_data,
    input  logic       ack_ready,
    output logic       ack_start,
    output logic [7:0] ack_data,
    output logic [8:0] mem_addr,
    output logic [11:0] mem_din,
    output logic       mem_we,
    output logic       cpu_rstn,
    output logic       busy,
    output logic       error
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_WRITE, S_CSUM, S_ACK
    } state_t;

    localparam logic [9:0] MAX_LEN = 10'(RAM_WORDS);
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    state_t      state_q, state_d;
    logic [8:0]  len_q, len_d, addr_q, addr_d;
    logic [3:0]  hi_q, hi_d;
    logic [11:0] word_q, word_d;
    logic [7:0]  sum_q, sum_d, ack_data_q, ack_data_d;
    logic        ack_start_q, ack_start_d, cpu_rstn_q, cpu_rstn_d;
    logic        busy_q, busy_d, error_q, error_d, boot_q;
    logic        fail, tmo_hit;
    logic [8:0]  len_cat;

    assign len_cat = {len_q[8], rx_data};

`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        tmo_active;
    assign tmo_active = (state_q != S_IDLE) && (state_q != S_ACK);
    assign tmo_hit    = tmo_active && (tmo_q == TIMEOUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else if (!tmo_active || rx_rcv) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        word_d      = word_q;
        sum_d       = sum_q;
        ack_data_d  = ack_data_q;
        ack_start_d = 1'b0;
        busy_d      = busy_q;
        error_d     = error_q;
        fail        = 1'b0;
        // The first clock after reset hands the CPU its boot-time run/halt choice.
        cpu_rstn_d  = boot_q ? cpu_rstn_q : BOOT_RUN;
        case (state_q)
            S_IDLE: if (rx_rcv && rx_data == CH_L) begin
                cpu_rstn_d = 1'b0;
                busy_d     = 1'b1;
                error_d    = 1'b0;
                addr_d     = '0;
                sum_d      = '0;
                state_d    = S_LEN_H;
            end
            S_LEN_H: if (rx_rcv) begin
                if (|rx_data[7:1]) fail = 1'b1;
                else begin
                    len_d   = {rx_data[0], 8'h00};
                    state_d = S_LEN_L;
                end
            end
            S_LEN_L: if (rx_rcv) begin
                if (len_cat == 9'd0 || {1'b0, len_cat} > MAX_LEN) fail = 1'b1;
                else begin
                    len_d   = len_cat;
                    state_d = S_DATA_H;
                end
            end
            S_DATA_H: if (rx_rcv) begin
                if (|rx_data[7:4]) fail = 1'b1;
                else begin
                    hi_d    = rx_data[3:0];
                    sum_d   = sum_q + rx_data;
                    state_d = S_DATA_L;
                end
            end
            S_DATA_L: if (rx_rcv) begin
                word_d  = {hi_q, rx_data};
                sum_d   = sum_q + rx_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q + 9'd1;
                state_d = (addr_q + 9'd1 == len_q) ? S_CSUM : S_DATA_H;
            end
            S_CSUM: if (rx_rcv) begin
                state_d = S_ACK;
                if (rx_data == sum_q) ack_data_d = CH_K;
                else begin
                    ack_data_d = CH_E;
                    error_d    = 1'b1;
                end
            end
            S_ACK: if (ack_ready) begin
                ack_start_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
                if (ack_data_q == CH_K) cpu_rstn_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (fail || tmo_hit) begin
            ack_data_d = CH_E;
            error_d    = 1'b1;
            state_d    = S_ACK;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            word_q      <= '0;
            sum_q       <= '0;
            ack_data_q  <= '0;
            ack_start_q <= 1'b0;
            cpu_rstn_q  <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            boot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            ack_data_q  <= ack_data_d;
            ack_start_q <= ack_start_d;
            cpu_rstn_q  <= cpu_rstn_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            boot_q      <= 1'b1;
        end
    end

    assign ack_start = ack_start_q;
    assign ack_data  = ack_data_q;
    assign mem_addr  = addr_q;
    assign mem_din   = word_q;
    assign mem_we    = (state_q == S_WRITE);
    assign cpu_rstn  = cpu_rstn_q;
    assign busy      = busy_q;
    assign error     = error_q;
endmodule

// File: tb/tb_simplez_loader.sv
// Directed bench for simplez_loader: good/bad frames, length limits, ack back-pressure, async reset, stall.
module tb_simplez_loader;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        rx_rcv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        ack_ready = 1'b1;
    logic        ack_start, mem_we, cpu_rstn, busy, error;
    logic [7:0]  ack_data;
    logic [8:0]  mem_addr;
    logic [11:0] mem_din;

    int checks = 0;
    int failures = 0;
    logic [20:0] exp_q[$];
    logic [20:0] wr_log[$];
    logic [8:0]  ack_log[$];
    logic [8:0]  ack_v;

    always #5 clk = ~clk;

    simplez_loader #(.BOOT_RUN(1'b1), .RAM_WORDS(504), .TIMEOUT(32'd100)) dut (
        .clk(clk), .rstn(rstn), .rx_rcv(rx_rcv), .rx_data(rx_data),
        .ack_ready(ack_ready), .ack_start(ack_start), .ack_data(ack_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .cpu_rstn(cpu_rstn), .busy(busy), .error(error)
    );

    always @(negedge clk) begin
        if (mem_we) wr_log.push_back({mem_addr, mem_din});
        if (ack_start) ack_log.push_back({cpu_rstn, ack_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        rx_rcv  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rcv  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        @(negedge clk);
    endtask

    task automatic send_lo(input logic [7:0] b);
        drive(b);
        chk("we_one_clock_after_lo", 32'(mem_we), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, output logic [8:0] v);
        int n = 0;
        while (ack_log.size() == 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(ack_log.size() != 0), 32'd1);
        v = (ack_log.size() != 0) ? ack_log.pop_front() : 9'h000;
    endtask

    task automatic check_writes(input string tag);
        logic [20:0] e, o;
        chk({tag, "_write_count"}, 32'(wr_log.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (wr_log.size() != 0) ? wr_log.pop_front() : 21'h0;
            chk({tag, "_write"}, 32'(o), 32'(e));
        end
        wr_log.delete();
    endtask

    initial begin
        // reset state
        #2 rstn = 1'b0;
        #1;
        chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ack_start", 32'(ack_start), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ack_data", 32'(ack_data), 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        chk("boot_cpu_rstn", 32'(cpu_rstn), 32'd1);

        // idle garbage is ignored
        send(8'h00); send(8'hFF);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_ack", 32'(ack_log.size()), 32'd0);
        chk("idle_no_write", 32'(wr_log.size()), 32'd0);

        // good 2-word frame
        send(8'h4C);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_held", 32'(cpu_rstn), 32'd0);
        send(8'h00); send(8'h02); send(8'h05); send_lo(8'hA3); send(8'h00); send_lo(8'h7F);
        send(8'h27);
        wait_ack("good", ack_v);
        chk("good_ack_char", 32'(ack_v[7:0]), 32'h4B);
        chk("good_cpu_rstn_at_ack", 32'(ack_v[8]), 32'd1);
        chk("good_error", 32'(error), 32'd0);
        chk("good_busy_done", 32'(busy), 32'd0);
        exp_q.push_back({9'd0, 12'h5A3});
        exp_q.push_back({9'd1, 12'h07F});
        check_writes("good");

        // bad checksum
        send(8'h4C); send(8'h00); send(8'h02); send(8'h05); send_lo(8'hA3); send(8'h00); send_lo(8'h7F);
        send(8'h28);
        wait_ack("badsum", ack_v);
        chk("badsum_ack_char", 32'(ack_v[7:0]), 32'h45);
        chk("badsum_cpu_held", 32'(ack_v[8]), 32'd0);
        chk("badsum_error", 32'(error), 32'd1);
        exp_q.push_back({9'd0, 12'h5A3});
        exp_q.push_back({9'd1, 12'h07F});
        check_writes("badsum");
        repeat (3) @(negedge clk);
        chk("badsum_cpu_stays_held", 32'(cpu_rstn), 32'd0);

        // LEN 505 rejected right after LEN_L
        send(8'h4C);
        chk("newframe_clears_error", 32'(error), 32'd0);
        send(8'h01); send(8'hF9);
        wait_ack("len505", ack_v);
        chk("len505_ack_char", 32'(ack_v[7:0]), 32'h45);
        chk("len505_error", 32'(error), 32'd1);
        check_writes("len505");

        // LEN 0, bad LEN_H, bad HI nibble
        send(8'h4C); send(8'h00); send(8'h00);
        wait_ack("len0", ack_v);
        chk("len0_ack_char", 32'(ack_v[7:0]), 32'h45);
        send(8'h4C); send(8'h02);
        wait_ack("lenh", ack_v);
        chk("lenh_ack_char", 32'(ack_v[7:0]), 32'h45);
        send(8'h4C); send(8'h00); send(8'h01); send(8'h15);
        wait_ack("badhi", ack_v);
        chk("badhi_ack_char", 32'(ack_v[7:0]), 32'h45);
        chk("badhi_error", 32'(error), 32'd1);
        send(8'h01); send(8'h02);
        chk("tail_ignored_busy", 32'(busy), 32'd0);
        check_writes("errs");

        // ack back-pressure
        send(8'h4C); send(8'h00); send(8'h01); send(8'h00); send_lo(8'h01);
        ack_ready = 1'b0;
        send(8'h01);
        repeat (100) @(negedge clk);
        chk("hold_no_ack", 32'(ack_log.size()), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_cpu_held", 32'(cpu_rstn), 32'd0);
        ack_ready = 1'b1;
        wait_ack("hold", ack_v);
        chk("hold_ack_char", 32'(ack_v[7:0]), 32'h4B);
        chk("hold_cpu_rstn_at_ack", 32'(ack_v[8]), 32'd1);
        exp_q.push_back({9'd0, 12'h001});
        check_writes("hold");

        // LEN 504 accepted, then async reset inside DATA_L
        send(8'h4C); send(8'h01); send(8'hF8);
        chk("len504_busy", 32'(busy), 32'd1);
        chk("len504_no_ack", 32'(ack_log.size()), 32'd0);
        send(8'h03);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_din", 32'(mem_din), 32'd0);
        chk("midrst_ack_data", 32'(ack_data), 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        chk("midrst_boot_cpu_rstn", 32'(cpu_rstn), 32'd1);
        send(8'h44);
        chk("midrst_busy_after", 32'(busy), 32'd0);
        check_writes("midrst");

        // stalled frame
        send(8'h4C); send(8'h00);
`ifdef SIMPLEZ_LOADER_TIMEOUT_EN
        wait_ack("timeout", ack_v);
        chk("timeout_ack_char", 32'(ack_v[7:0]), 32'h45);
        chk("timeout_error", 32'(error), 32'd1);
`else
        repeat (150) @(negedge clk);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_no_ack", 32'(ack_log.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
